// File: rtl/text_pixel_gen.sv
// Text-mode pixel pipeline: raster position -> text buffer address -> glyph
// index -> glyph pixel. hsync, vsync and de are delayed to line up with the
// pixel. Reverse video and a blinking underline cursor are applied at the output.
module text_pixel_gen #(
  parameter int COLS            = 80,
  parameter int ROWS            = 30,
  parameter int CHAR_W          = 8,
  parameter int CHAR_H          = 16,
  parameter int POS_WIDTH       = 11,
  parameter int TEXT_ADDR_WIDTH = 12,
  parameter int FONT_ADDR_WIDTH = 7,
  parameter int FONT_DATA_WIDTH = 128,
  parameter int BLINK_FRAMES    = 30,
  parameter int SYNC_IDLE       = 1
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [POS_WIDTH-1:0]       hcount_i,
  input  logic [POS_WIDTH-1:0]       vcount_i,
  input  logic                       de_i,
  input  logic                       hsync_i,
  input  logic                       vsync_i,
  output logic [TEXT_ADDR_WIDTH-1:0] text_addr_o,
  input  logic [7:0]                 char_i,
  output logic [FONT_ADDR_WIDTH-1:0] font_addr_o,
  input  logic [0:FONT_DATA_WIDTH-1] glyph_i,
  input  logic                       cursor_en_i,
  input  logic [6:0]                 cursor_col_i,
  input  logic [4:0]                 cursor_row_i,
  output logic                       pixel_o,
  output logic                       de_o,
  output logic                       hsync_o,
  output logic                       vsync_o
);

  localparam int unsigned XW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int unsigned YW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int unsigned GW = (FONT_DATA_WIDTH > 1) ? $clog2(FONT_DATA_WIDTH) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic              L_IDLE       = (SYNC_IDLE != 0);
  localparam logic [31:0]       L_COLS       = 32'(COLS);
  localparam logic [31:0]       L_ROWS       = 32'(ROWS);
  localparam logic [31:0]       L_CHAR_W     = 32'(CHAR_W);
  localparam logic [31:0]       L_CHAR_H     = 32'(CHAR_H);
  localparam logic [31:0]       L_CUR_Y      = 32'(CHAR_H - 2);
  localparam logic [FW-1:0]     L_FRAME_LAST = FW'(BLINK_FRAMES - 1);

  // Raster decode (combinational, cycle 0)
  logic [31:0]   w_hc;
  logic [31:0]   w_vc;
  logic [31:0]   w_col;
  logic [31:0]   w_row;
  logic [XW-1:0] w_xo;
  logic [YW-1:0] w_yo;
  logic          w_oor;
  logic          w_cur;
  logic          w_vs_event;

  // Blink state
  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic          r_vs_prev;

  // Side-band pipelines; index k holds the value for stage k+1
  logic [3:0]          r_de_p;
  logic [3:0]          r_hs_p;
  logic [3:0]          r_vs_p;
  logic [3:0]          r_oor_p;
  logic [3:0]          r_cur_p;
  logic [3:0][XW-1:0]  r_xo_p;
  logic [3:0][YW-1:0]  r_yo_p;

  // Data path registers
  logic [7:0]                 r_char;
  logic                       r_rev3;
  logic                       r_rev4;
  logic [0:FONT_DATA_WIDTH-1] r_glyph;

  logic [GW-1:0] w_gidx;
  logic          w_bit;

  assign w_hc  = 32'(hcount_i);
  assign w_vc  = 32'(vcount_i);
  assign w_col = w_hc / L_CHAR_W;
  assign w_row = w_vc / L_CHAR_H;
  assign w_xo  = XW'(w_hc % L_CHAR_W);
  assign w_yo  = YW'(w_vc % L_CHAR_H);
  assign w_oor = !de_i || (w_col >= L_COLS) || (w_row >= L_ROWS);
  assign w_cur = cursor_en_i && r_blink &&
                 (w_col == 32'(cursor_col_i)) && (w_row == 32'(cursor_row_i)) &&
                 (32'(w_yo) >= L_CUR_Y);
  assign w_vs_event = (vsync_i != L_IDLE) && (r_vs_prev == L_IDLE);

  assign w_gidx = GW'(32'(r_yo_p[3]) * L_CHAR_W + 32'(r_xo_p[3]));
  assign w_bit  = r_glyph[w_gidx];

  // Frame counter and cursor blink toggle, advanced on each vsync assertion
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_frame   <= '0;
      r_blink   <= 1'b1;
      r_vs_prev <= L_IDLE;
    end else begin
      r_vs_prev <= vsync_i;
      if (w_vs_event) begin
        if (r_frame == L_FRAME_LAST) begin
          r_frame <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  // Stage 1: text buffer address
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      text_addr_o <= '0;
    end else begin
      text_addr_o <= TEXT_ADDR_WIDTH'(w_row * L_COLS + w_col);
    end
  end

  // Stages 2-4: capture character, issue glyph index, capture glyph bitmap
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_char      <= '0;
      font_addr_o <= '0;
      r_rev3      <= 1'b0;
      r_rev4      <= 1'b0;
      r_glyph     <= '0;
    end else begin
      r_char      <= char_i;
      font_addr_o <= FONT_ADDR_WIDTH'(r_char[6:0]);
      r_rev3      <= r_char[7];
      r_rev4      <= r_rev3;
      r_glyph     <= glyph_i;
    end
  end

  // Side-band delay lines carrying sync/de and per-pixel cell information
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_de_p  <= '0;
      r_hs_p  <= {4{L_IDLE}};
      r_vs_p  <= {4{L_IDLE}};
      r_oor_p <= '0;
      r_cur_p <= '0;
      r_xo_p  <= '0;
      r_yo_p  <= '0;
    end else begin
      r_de_p  <= {r_de_p[2:0], de_i};
      r_hs_p  <= {r_hs_p[2:0], hsync_i};
      r_vs_p  <= {r_vs_p[2:0], vsync_i};
      r_oor_p <= {r_oor_p[2:0], w_oor};
      r_cur_p <= {r_cur_p[2:0], w_cur};
      r_xo_p  <= {r_xo_p[2:0], w_xo};
      r_yo_p  <= {r_yo_p[2:0], w_yo};
    end
  end

  // Stage 5: pixel select and aligned sync/de outputs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pixel_o <= 1'b0;
      de_o    <= 1'b0;
      hsync_o <= L_IDLE;
      vsync_o <= L_IDLE;
    end else begin
      pixel_o <= r_de_p[3] & ~r_oor_p[3] & (w_bit ^ r_rev4 ^ r_cur_p[3]);
      de_o    <= r_de_p[3];
      hsync_o <= r_hs_p[3];
      vsync_o <= r_vs_p[3];
    end
  end

endmodule
